// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, bubble and optional skid entry
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             drain;

    assign main_valid  = (state_q != ST_EMPTY);
    assign skid_valid  = (state_q == ST_TWO);
    assign out_valid_o = main_valid & ~stall_i;
    assign out_data_o  = main_data_q;
    assign occupancy_o = state_q;

    // With the skid entry, ready is cut off from out_ready_i so it never chains upstream.
    if (SKID) begin : g_skid_ready
        assign in_ready_o = ~skid_valid & ~stall_i & ~flush_i;
    end else begin : g_plain_ready
        assign in_ready_o = ~stall_i & ~flush_i & (~main_valid | out_ready_i);
    end

    assign accept = in_valid_i & in_ready_o;
    assign drain  = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d     = ST_EMPTY;
            main_data_d = NOP_VALUE;
            skid_data_d = NOP_VALUE;
        end else if (!stall_i) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data_i;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_data_d = in_data_i;
                    end else if (accept) begin
                        // Only reachable with SKID: the plain register needs a drain to accept when full.
                        state_d     = ST_TWO;
                        skid_data_d = in_data_i;
                    end else if (drain) begin
                        state_d     = ST_EMPTY;
                        main_data_d = NOP_VALUE;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        skid_data_d = NOP_VALUE;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = NOP_VALUE;
                    skid_data_d = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= NOP_VALUE;
            skid_data_q <= NOP_VALUE;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized scoreboard bench for pipe_stage_reg (skid and plain variants)
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, id, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int           W    = (g == 0) ? 32 : 8;
        localparam bit           SK   = (g == 0);
        localparam logic [W-1:0] NOPV = (g == 0) ? {W{1'b0}} : W'(8'h13);

        logic         flush, stall, in_valid, in_ready, out_valid, out_ready;
        logic [W-1:0] in_data, out_data;
        logic [1:0]   occ;
        logic [W-1:0] sb[$];
        int           n_xfer = 0;

        pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOPV), .SKID(SK)) dut (
            .clk_i      (clk),
            .rst        (rst),
            .flush_i    (flush),
            .stall_i    (stall),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready),
            .in_data_i  (in_data),
            .out_valid_o(out_valid),
            .out_ready_i(out_ready),
            .out_data_o (out_data),
            .occupancy_o(occ)
        );

        // Reference: a FIFO of capacity 2 (skid) or 1 (plain), with ready rules from the protocol.
        function automatic bit exp_ir(input int sz);
            if (SK) return (sz < 2) && !stall && !flush;
            return !stall && !flush && (sz == 0 || out_ready);
        endfunction

        task automatic check_comb();
            int sz;
            sz = sb.size();
            chk("occupancy", g, 64'(occ), 64'(sz));
            chk("out_valid", g, 64'(out_valid), 64'(sz > 0 && !stall));
            chk("in_ready", g, 64'(in_ready), 64'(exp_ir(sz)));
            chk("out_data", g, 64'(out_data), 64'((sz > 0) ? sb[0] : NOPV));
        endtask

        initial begin : driver
            bit exp_acc;
            int mode;
            int cyc;
            mode = 0;
            cyc = 0;
            flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
            forever begin
                @(negedge clk);
                if (cyc % 16 == 0) mode = $urandom_range(0, 2);
                cyc++;
                stall    = ($urandom_range(0, 9) == 0);
                flush    = ($urandom_range(0, 15) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
                out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
                #1;
                if (!rst) check_comb();
                if (!SK && $urandom_range(0, 3) == 0) begin
                    out_ready = ~out_ready;
                    #1;
                    if (!rst) check_comb();
                end else begin
                    #1;
                end
                exp_acc = in_valid && exp_ir(sb.size());
                #2;
                if (rst) begin
                    sb.delete();
                    chk("rst_out_valid", g, 64'(out_valid), 64'(0));
                    chk("rst_occupancy", g, 64'(occ), 64'(0));
                    chk("rst_out_data", g, 64'(out_data), 64'(NOPV));
                end else if (flush) begin
                    sb.delete();
                end else if (exp_acc) begin
                    sb.push_back(in_data);
                end
            end
        end

        initial begin : monitor
            forever begin
                @(negedge clk);
                #3;
                if (!rst && out_valid && out_ready) begin
                    n_xfer++;
                    if (sb.size() == 0) chk("spurious_out", g, 64'(out_valid), 64'(0));
                    else chk("drain_data", g, 64'(out_data), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (1500) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (1500) @(negedge clk);
        chk("traffic", 0, 64'(g_inst[0].n_xfer > 200), 64'(1));
        chk("traffic", 1, 64'(g_inst[1].n_xfer > 200), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
